// File: rtl/refcpu_context_unit_pkg.sv
// Shared definitions for the reference CPU context unit.
// Latency: n/a (types, constants and a reset helper only).
// Backpressure: n/a.
package refcpu_context_unit_pkg;

  // Multi-cycle CPU control states. S_UNKNOWN marks an illegal requested state.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXECUTE   = 4'd2,
    S_MEMORY    = 4'd3,
    S_WRITEBACK = 4'd4,
    S_UNKNOWN   = 4'd15
  } cpu_state_t;

  localparam logic [3:0] LAST_CPU_STATE = 4'd4;

  typedef enum logic {
    SEL_GPR = 1'b0,
    SEL_TMP = 1'b1
  } reg_sel_t;

  typedef struct packed {
    logic       en;
    reg_sel_t   sel;
    logic [4:0] idx;
    logic [31:0] data;
  } wr_req_t;

  // Architectural state that survives an abort.
  typedef struct packed {
    logic [31:0][31:0] r;
    logic [31:0]       hi;
    logic [31:0]       lo;
    logic [31:0]       pc;
    logic [31:0]       next_pc;
    logic              delayed;
    logic [31:0]       delayed_pc;
  } snapshot_t;

  // Snapshot contents right after reset for a given reset PC.
  function automatic snapshot_t snapshot_reset(input logic [31:0] reset_pc);
    snapshot_t s;
    s         = '0;
    s.pc      = reset_pc;
    s.next_pc = reset_pc + 32'd4;
    return s;
  endfunction

endpackage

// File: rtl/refcpu_context_unit_wr_merge.sv
// Resolves the register write ports into per-register enables and data.
// Latency: combinational, zero cycles.
// Backpressure: none; every enabled request is resolved in the same cycle.
//
// Ports:
//   wr_req         - NUM_WR write requests {en, sel, idx, data}
//   gpr_we/gpr_wd  - per-GPR write enable and data (r[0] never enabled)
//   tmp_we/tmp_wd  - per-TMP write enable and data (out-of-range idx dropped)
module refcpu_context_unit_wr_merge
  import refcpu_context_unit_pkg::*;
#(
  parameter int NUM_WR  = 2,
  parameter int NUM_TMP = 8
) (
  input  wr_req_t [NUM_WR-1:0]        wr_req,
  output logic    [31:0]              gpr_we,
  output logic    [31:0][31:0]        gpr_wd,
  output logic    [NUM_TMP-1:0]       tmp_we,
  output logic    [NUM_TMP-1:0][31:0] tmp_wd
);

  // Ports are walked in ascending order so a later (higher) port overwrites
  // an earlier one aimed at the same register.
  always_comb begin
    gpr_we = '0;
    gpr_wd = '0;
    tmp_we = '0;
    tmp_wd = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_req[p].en) begin
        if (wr_req[p].sel == SEL_GPR) begin
          if (wr_req[p].idx != 5'd0) begin
            gpr_we[wr_req[p].idx] = 1'b1;
            gpr_wd[wr_req[p].idx] = wr_req[p].data;
          end
        end else begin
          // Matching only implemented entries drops out-of-range indices.
          for (int j = 0; j < NUM_TMP; j++) begin
            if (wr_req[p].idx == 5'(j)) begin
              tmp_we[j] = 1'b1;
              tmp_wd[j] = wr_req[p].data;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/refcpu_context_unit.sv
// Architectural context of the multi-cycle CPU with commit snapshot/rollback.
// Latency: updates visible one cycle after the edge; reads are combinational.
// Backpressure: none; writes, commits and aborts are accepted every cycle.
//
// Ports:
//   clk, resetn               - clock, synchronous active-low reset
//   wr_req, hilo_we, hi/lo_in - register and HI/LO write requests
//   rd_sel, rd_idx, rd_data   - combinational register read ports
//   state_we, next_state      - FSM state load (ignored on commit/abort)
//   commit, branch_valid/_target, abort - retire / roll back control
//   state..lo, retired, err_branch_in_slot - current context outputs
module refcpu_context_unit
  import refcpu_context_unit_pkg::*;
#(
  parameter int          NUM_TMP  = 8,
  parameter int          NUM_WR   = 2,
  parameter int          NUM_RD   = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  wr_req_t [NUM_WR-1:0]     wr_req,
  input  logic    [1:0]            hilo_we,
  input  logic    [31:0]           hi_in,
  input  logic    [31:0]           lo_in,
  input  logic    [NUM_RD-1:0]     rd_sel,
  input  logic    [NUM_RD-1:0][4:0] rd_idx,
  output logic    [NUM_RD-1:0][31:0] rd_data,
  input  logic                     state_we,
  input  cpu_state_t               next_state,
  input  logic                     commit,
  input  logic                     branch_valid,
  input  logic    [31:0]           branch_target,
  input  logic                     abort,
  output cpu_state_t               state,
  output logic    [31:0]           pc,
  output logic    [31:0]           next_pc,
  output logic                     delayed,
  output logic    [31:0]           delayed_pc,
  output logic    [31:0]           hi,
  output logic    [31:0]           lo,
  output logic    [CNT_W-1:0]      retired,
  output logic                     err_branch_in_slot
);

  logic [31:0][31:0]        gpr;
  logic [NUM_TMP-1:0][31:0] tmp;
  snapshot_t                snap;

  logic [31:0]              gpr_we;
  logic [31:0][31:0]        gpr_wd;
  logic [NUM_TMP-1:0]       tmp_we;
  logic [NUM_TMP-1:0][31:0] tmp_wd;

  logic [31:0][31:0]        gpr_nxt;
  logic [NUM_TMP-1:0][31:0] tmp_nxt;
  logic [31:0]              hi_nxt;
  logic [31:0]              lo_nxt;

  logic [31:0]              pc_c;
  logic [31:0]              next_pc_c;
  logic                     delayed_c;
  logic [31:0]              delayed_pc_c;
  logic                     err_set;

  refcpu_context_unit_wr_merge #(
    .NUM_WR  (NUM_WR),
    .NUM_TMP (NUM_TMP)
  ) u_wr_merge (
    .wr_req (wr_req),
    .gpr_we (gpr_we),
    .gpr_wd (gpr_wd),
    .tmp_we (tmp_we),
    .tmp_wd (tmp_wd)
  );

  // Post-write register file; the snapshot captures these so same-cycle
  // writes of a committing instruction are part of the committed state.
  always_comb begin
    gpr_nxt = gpr;
    for (int i = 1; i < 32; i++) begin
      if (gpr_we[i]) gpr_nxt[i] = gpr_wd[i];
    end
    tmp_nxt = tmp;
    for (int j = 0; j < NUM_TMP; j++) begin
      if (tmp_we[j]) tmp_nxt[j] = tmp_wd[j];
    end
    hi_nxt = hilo_we[1] ? hi_in : hi;
    lo_nxt = hilo_we[0] ? lo_in : lo;
  end

  // PC advance on commit. A branch retiring in a delay slot cannot start a
  // new slot; it is dropped and flagged instead.
  always_comb begin
    pc_c         = next_pc;
    delayed_c    = 1'b0;
    delayed_pc_c = delayed_pc;
    err_set      = 1'b0;
    if (delayed) begin
      pc_c    = delayed_pc;
      err_set = branch_valid;
    end else if (branch_valid) begin
      delayed_c    = 1'b1;
      delayed_pc_c = branch_target;
    end
    next_pc_c = pc_c + 32'd4;
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_data[p] = '0;
      if (rd_sel[p] == SEL_GPR) begin
        if (rd_idx[p] != 5'd0) rd_data[p] = gpr[rd_idx[p]];
      end else begin
        for (int j = 0; j < NUM_TMP; j++) begin
          if (rd_idx[p] == 5'(j)) rd_data[p] = tmp[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state              <= S_FETCH;
      pc                 <= RESET_PC;
      next_pc            <= RESET_PC + 32'd4;
      delayed            <= 1'b0;
      delayed_pc         <= '0;
      hi                 <= '0;
      lo                 <= '0;
      gpr                <= '0;
      tmp                <= '0;
      retired            <= '0;
      err_branch_in_slot <= 1'b0;
      snap               <= snapshot_reset(RESET_PC);
    end else if (abort) begin
      gpr        <= snap.r;
      hi         <= snap.hi;
      lo         <= snap.lo;
      pc         <= snap.pc;
      next_pc    <= snap.next_pc;
      delayed    <= snap.delayed;
      delayed_pc <= snap.delayed_pc;
      tmp        <= '0;
      state      <= S_FETCH;
    end else begin
      gpr <= gpr_nxt;
      tmp <= tmp_nxt;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      if (commit) begin
        pc         <= pc_c;
        next_pc    <= next_pc_c;
        delayed    <= delayed_c;
        delayed_pc <= delayed_pc_c;
        state      <= S_FETCH;
        retired    <= retired + CNT_W'(1);
        if (err_set) err_branch_in_slot <= 1'b1;
        snap <= '{r: gpr_nxt, hi: hi_nxt, lo: lo_nxt, pc: pc_c,
                  next_pc: next_pc_c, delayed: delayed_c,
                  delayed_pc: delayed_pc_c};
      end else if (state_we) begin
        state <= (next_state > LAST_CPU_STATE) ? S_UNKNOWN : next_state;
      end
    end
  end

endmodule
